axi_sram_bridge_mp: RTL



---
 rtl/axi_sram_bridge_mp_pkg.sv | 23 ++
 rtl/axi_sram_bridge_mp_rr_arbiter.sv | 52 +++++
 rtl/axi_sram_bridge_mp.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_bridge_mp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_sram_bridge_mp_pkg : shared types/constants for the multi-port bridge |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package axi_sram_bridge_mp_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;

  // SRAM size code 3 has no wider AXI meaning, so it collapses to a word.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, (size == 2'b11) ? 2'b10 : size};
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_sram_bridge_mp_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_sram_bridge_mp_rr_arbiter : round-robin, one-hot grant, advance on    |
// | accept only. Revision: 1.0                                               |
// +--------------------------------------------------------------------------+
module axi_sram_bridge_mp_rr_arbiter
  import axi_sram_bridge_mp_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [N-1:0] i_req,
  input  logic         i_accept,
  output logic [N-1:0] o_gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win;
  logic [PW-1:0] w_nxt;
  logic [N-1:0]  w_mask;
  logic [N-1:0]  w_hi;
  logic [N-1:0]  w_pool;

  // Requests at or above the pointer take priority; otherwise wrap to the bottom.
  always_comb begin
    w_mask = '0;
    for (int j = 0; j < N; j++) begin
      w_mask[j] = (j >= int'(r_ptr));
    end
    w_hi   = i_req & w_mask;
    w_pool = (|w_hi) ? w_hi : i_req;
    o_gnt  = w_pool & (~w_pool + N'(1));
    w_win  = '0;
    for (int j = 0; j < N; j++) begin
      if (o_gnt[j]) w_win = PW'(j);
    end
    w_nxt = (int'(w_win) == N - 1) ? '0 : w_win + PW'(1);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_ptr <= '0;
    end else if (i_accept && (|o_gnt)) begin
      r_ptr <= w_nxt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_sram_bridge_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | axi_sram_bridge_mp : N SRAM-like ports -> single-beat AXI3, reads        |
// | pipelined, one write. Option: BRIDGE_RAW_ADDR_CHECK_EN. Revision: 1.0    |
// +--------------------------------------------------------------------------+
module axi_sram_bridge_mp
  import axi_sram_bridge_mp_pkg::*;
#(
  parameter int N_PORTS    = 2,
  parameter int ID_W       = 4,
  parameter int MAX_RD_OUT = 2
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [N_PORTS-1:0]     i_s_req,
  input  logic [N_PORTS-1:0]     i_s_wr,
  input  logic [2*N_PORTS-1:0]   i_s_size,
  input  logic [32*N_PORTS-1:0]  i_s_addr,
  input  logic [32*N_PORTS-1:0]  i_s_wdata,
  input  logic [4*N_PORTS-1:0]   i_s_wstrb,
  output logic [N_PORTS-1:0]     o_s_addr_ok,
  output logic [N_PORTS-1:0]     o_s_data_ok,
  output logic [32*N_PORTS-1:0]  o_s_rdata,
  output logic [ID_W-1:0]        o_arid,
  output logic [31:0]            o_araddr,
  output logic [3:0]             o_arlen,
  output logic [2:0]             o_arsize,
  output logic [1:0]             o_arburst,
  output logic [1:0]             o_arlock,
  output logic [3:0]             o_arcache,
  output logic [2:0]             o_arprot,
  output logic                   o_arvalid,
  input  logic                   i_arready,
  input  logic [ID_W-1:0]        i_rid,
  input  logic [31:0]            i_rdata,
  input  logic [1:0]             i_rresp,
  input  logic                   i_rlast,
  input  logic                   i_rvalid,
  output logic                   o_rready,
  output logic [ID_W-1:0]        o_awid,
  output logic [31:0]            o_awaddr,
  output logic [3:0]             o_awlen,
  output logic [2:0]             o_awsize,
  output logic [1:0]             o_awburst,
  output logic [1:0]             o_awlock,
  output logic [3:0]             o_awcache,
  output logic [2:0]             o_awprot,
  output logic                   o_awvalid,
  input  logic                   i_awready,
  output logic [ID_W-1:0]        o_wid,
  output logic [31:0]            o_wdata,
  output logic [3:0]             o_wstrb,
  output logic                   o_wlast,
  output logic                   o_wvalid,
  input  logic                   i_wready,
  input  logic [ID_W-1:0]        i_bid,
  input  logic [1:0]             i_bresp,
  input  logic                   i_bvalid,
  output logic                   o_bready
);

  localparam int CW = $clog2(MAX_RD_OUT + 1);

  wr_state_t             r_wstate;
  wr_state_t             w_wstate_nxt;
  logic [CW-1:0]         r_rd_cnt;
  logic                  r_arvalid;
  logic [31:0]           r_araddr;
  logic [2:0]            r_arsize;
  logic [ID_W-1:0]       r_arid;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic [31:0]           r_awaddr;
  logic [2:0]            r_awsize;
  logic [ID_W-1:0]       r_awid;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic [N_PORTS-1:0]    r_data_ok;
  logic [32*N_PORTS-1:0] r_rdata;

  logic [N_PORTS-1:0]    w_rd_req;
  logic [N_PORTS-1:0]    w_wr_req;
  logic [N_PORTS-1:0]    w_rd_gnt;
  logic [N_PORTS-1:0]    w_wr_gnt;
  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic                  w_rd_hazard;
  logic                  w_ar_hs;
  logic                  w_aw_done;
  logic                  w_w_done;
  logic [31:0]           w_rd_addr;
  logic [1:0]            w_rd_size;
  logic [ID_W-1:0]       w_rd_id;
  logic [31:0]           w_wr_addr;
  logic [1:0]            w_wr_size;
  logic [ID_W-1:0]       w_wr_id;
  logic [31:0]           w_wr_data;
  logic [3:0]            w_wr_strb;
  logic [N_PORTS-1:0]    w_dok_nxt;
  logic                  w_unused;

  assign w_unused = ^{i_rresp, i_rlast, i_bid, i_bresp};

  assign w_rd_req = i_s_req & ~i_s_wr;
  assign w_wr_req = i_s_req & i_s_wr;

  axi_sram_bridge_mp_rr_arbiter #(.N(N_PORTS)) u_rd_arb (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .i_req    (w_rd_req),
    .i_accept (w_rd_ok),
    .o_gnt    (w_rd_gnt)
  );

  axi_sram_bridge_mp_rr_arbiter #(.N(N_PORTS)) u_wr_arb (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .i_req    (w_wr_req),
    .i_accept (w_wr_ok),
    .o_gnt    (w_wr_gnt)
  );

  always_comb begin
    w_rd_addr = '0;
    w_rd_size = '0;
    w_rd_id   = '0;
    w_wr_addr = '0;
    w_wr_size = '0;
    w_wr_id   = '0;
    w_wr_data = '0;
    w_wr_strb = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (w_rd_gnt[p]) begin
        w_rd_addr = i_s_addr[p*32 +: 32];
        w_rd_size = i_s_size[p*2 +: 2];
        w_rd_id   = ID_W'(p);
      end
      if (w_wr_gnt[p]) begin
        w_wr_addr = i_s_addr[p*32 +: 32];
        w_wr_size = i_s_size[p*2 +: 2];
        w_wr_id   = ID_W'(p);
        w_wr_data = i_s_wdata[p*32 +: 32];
        w_wr_strb = i_s_wstrb[p*4 +: 4];
      end
    end
  end

`ifdef BRIDGE_RAW_ADDR_CHECK_EN
  assign w_rd_hazard = (r_wstate != W_IDLE) && (w_rd_addr[31:2] == r_awaddr[31:2]);
`else
  assign w_rd_hazard = (r_wstate != W_IDLE);
`endif

  // A pending AR not yet counted in r_rd_cnt blocks new grants, so the count never overshoots.
  assign w_rd_ok = (|w_rd_req) && !r_arvalid && (r_rd_cnt < CW'(MAX_RD_OUT)) && !w_rd_hazard;
  assign w_wr_ok = (|w_wr_req) && (r_wstate == W_IDLE) && (r_rd_cnt == '0);

  assign o_s_addr_ok = ({N_PORTS{w_rd_ok}} & w_rd_gnt) | ({N_PORTS{w_wr_ok}} & w_wr_gnt);

  assign w_ar_hs   = r_arvalid && i_arready;
  assign w_aw_done = !r_awvalid || i_awready;
  assign w_w_done  = !r_wvalid || i_wready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arsize  <= '0;
      r_arid    <= '0;
    end else if (w_rd_ok) begin
      r_arvalid <= 1'b1;
      r_araddr  <= w_rd_addr;
      r_arsize  <= axi_size(w_rd_size);
      r_arid    <= w_rd_id;
    end else if (i_arready) begin
      r_arvalid <= 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rd_cnt <= '0;
    end else begin
      case ({w_ar_hs, i_rvalid})
        2'b10:   r_rd_cnt <= r_rd_cnt + CW'(1);
        2'b01:   if (r_rd_cnt != '0) r_rd_cnt <= r_rd_cnt - CW'(1);
        default: r_rd_cnt <= r_rd_cnt;
      endcase
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (w_wr_ok) w_wstate_nxt = W_ADDR;
      W_ADDR:  if (w_aw_done && w_w_done) w_wstate_nxt = W_RESP;
      W_RESP:  if (i_bvalid) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nxt;
  end

  // AW and W rise together; each drops on its own ready.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_awaddr  <= '0;
      r_awsize  <= '0;
      r_awid    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_wr_ok) begin
      r_awvalid <= 1'b1;
      r_wvalid  <= 1'b1;
      r_awaddr  <= w_wr_addr;
      r_awsize  <= axi_size(w_wr_size);
      r_awid    <= w_wr_id;
      r_wdata   <= w_wr_data;
      r_wstrb   <= w_wr_strb;
    end else begin
      if (i_awready) r_awvalid <= 1'b0;
      if (i_wready)  r_wvalid  <= 1'b0;
    end
  end

  always_comb begin
    w_dok_nxt = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (i_rvalid && (i_rid == ID_W'(p))) w_dok_nxt[p] = 1'b1;
      if ((r_wstate == W_RESP) && i_bvalid && (r_awid == ID_W'(p))) w_dok_nxt[p] = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_data_ok <= '0;
      r_rdata   <= '0;
    end else begin
      r_data_ok <= w_dok_nxt;
      for (int p = 0; p < N_PORTS; p++) begin
        if (i_rvalid && (i_rid == ID_W'(p))) r_rdata[p*32 +: 32] <= i_rdata;
      end
    end
  end

  assign o_s_data_ok = r_data_ok;
  assign o_s_rdata   = r_rdata;

  assign o_arid    = r_arid;
  assign o_araddr  = r_araddr;
  assign o_arlen   = AXI_LEN_SINGLE;
  assign o_arsize  = r_arsize;
  assign o_arburst = AXI_BURST_INCR;
  assign o_arlock  = 2'b00;
  assign o_arcache = 4'b0000;
  assign o_arprot  = 3'b000;
  assign o_arvalid = r_arvalid;
  assign o_rready  = 1'b1;

  assign o_awid    = r_awid;
  assign o_awaddr  = r_awaddr;
  assign o_awlen   = AXI_LEN_SINGLE;
  assign o_awsize  = r_awsize;
  assign o_awburst = AXI_BURST_INCR;
  assign o_awlock  = 2'b00;
  assign o_awcache = 4'b0000;
  assign o_awprot  = 3'b000;
  assign o_awvalid = r_awvalid;
  assign o_wid     = r_awid;
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_wstrb;
  assign o_wlast   = 1'b1;
  assign o_wvalid  = r_wvalid;
  assign o_bready  = 1'b1;

endmodule
`default_nettype wire
